// File: rtl/soc_pkg.sv
// Shared protocol constants for the instruction fetch path.
// Contents: bus widths, wait-state and outstanding limits, response error
// codes, and a helper that flags misaligned or out-of-range word addresses.
package soc_pkg;

  localparam int DATA_W                = 32;
  localparam int ADDR_W                = 32;
  localparam int MAX_WAIT_STATES       = 7;
  localparam int MAX_OUTSTANDING_LIMIT = 8;
  localparam int OUTSTANDING_W         = 4;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_ADDR = 1'b1;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // True when a byte address is not word aligned or its word index does
  // not fit in an array with idx_w index bits.
  function automatic logic addr_bad(input addr_t addr, input int unsigned idx_w);
    return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 32'd2)) != '0);
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Instruction fetch bus between a requester (master) and the memory
// responder (slave).
// Signals: instr_req_in / instr_addr_in from the requester; gnt_out,
// instr_rvalid_out, instr_rdata_out, instr_err_out from the responder.
interface instr_mem_responder_if;
  import soc_pkg::*;

  logic  instr_req_in;
  addr_t instr_addr_in;
  logic  gnt_out;
  logic  instr_rvalid_out;
  word_t instr_rdata_out;
  logic  instr_err_out;

  modport master (
    output instr_req_in, instr_addr_in,
    input  gnt_out, instr_rvalid_out, instr_rdata_out, instr_err_out
  );

  modport slave (
    input  instr_req_in, instr_addr_in,
    output gnt_out, instr_rvalid_out, instr_rdata_out, instr_err_out
  );

endinterface

// File: rtl/instr_mem_responder_resp_pipe.sv
// resp_pipe: fixed-latency, in-order response delay line.
// Ports: clk, rst (sync, active-high, clears every stage); in_valid/in_data/
// in_err enter stage 0 on the rising edge; out_* present the last stage.
// Data and error are stored as zero in empty stages so the outputs are
// already clean whenever out_valid is low.
module resp_pipe
  import soc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  word_t in_data,
  input  logic  in_err,
  output logic  out_valid,
  output word_t out_data,
  output logic  out_err
);

  logic  valid_q [DEPTH];
  word_t data_q  [DEPTH];
  logic  err_q   [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        err_q[i]   <= 1'b0;
      end
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_valid ? in_data : '0;
      err_q[0]   <= in_valid & in_err;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_err   = err_q[DEPTH-1];

endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: instruction memory with fixed-latency, in-order
// fetch responses and a program-load write port.
// Ports: clk, rst (sync, active-high); bus (slave side of the fetch
// interface); load_en_in / load_addr_in / load_data_in write one word per
// edge. The word is read at grant time and carried through resp_pipe, so
// the response appears WAIT_STATES+1 cycles after the grant cycle.
module instr_mem_responder
  import soc_pkg::*;
#(
  parameter int MEM_DEPTH       = 1024,
  parameter int WAIT_STATES     = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_mem_responder_if.slave  bus,
  input  logic                  load_en_in,
  input  addr_t                 load_addr_in,
  input  word_t                 load_data_in
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  // Out-of-range wait-state settings saturate at the protocol limit.
  localparam int PIPE_DEPTH =
    ((WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES) + 1;
  localparam logic [OUTSTANDING_W-1:0] MAX_OUT = OUTSTANDING_W'(MAX_OUTSTANDING);

  word_t mem [MEM_DEPTH];

  logic [IDX_W-1:0]         req_idx;
  logic [IDX_W-1:0]         load_idx;
  logic                     req_err;
  logic                     load_bad;
  logic                     grant;
  logic                     rsp;
  word_t                    rd_word;
  logic [OUTSTANDING_W-1:0] outstanding;
  logic [OUTSTANDING_W-1:0] outstanding_nxt;

  logic  pipe_valid;
  word_t pipe_data;
  logic  pipe_err;

  assign req_idx  = bus.instr_addr_in[IDX_W+1:2];
  assign load_idx = load_addr_in[IDX_W+1:2];
  assign req_err  = addr_bad(bus.instr_addr_in, IDX_W);
  assign load_bad = addr_bad(load_addr_in, IDX_W);
  assign rd_word  = req_err ? '0 : mem[req_idx];

  // A load owns the array for its cycle, so fetches wait one cycle.
  assign grant = bus.instr_req_in & ~load_en_in & (outstanding < MAX_OUT) & ~rst;
  assign bus.gnt_out = grant;

  always_ff @(posedge clk) begin
    if (load_en_in && !load_bad) begin
      mem[load_idx] <= load_data_in;
    end
  end

  resp_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_resp_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (grant),
    .in_data   (rd_word),
    .in_err    (req_err ? ERR_ADDR : ERR_NONE),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .out_err   (pipe_err)
  );

  // Responses are masked while rst is high so the bus is quiet for the
  // whole reset cycle, not just from the edge after it.
  assign rsp                  = pipe_valid & ~rst;
  assign bus.instr_rvalid_out = rsp;
  assign bus.instr_rdata_out  = rsp ? pipe_data : '0;
  assign bus.instr_err_out    = rsp & pipe_err;

  always_comb begin
    outstanding_nxt = outstanding;
    if (grant && !rsp) begin
      outstanding_nxt = outstanding + 1'b1;
    end else if (!grant && rsp && (outstanding != '0)) begin
      outstanding_nxt = outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_nxt;
    end
  end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between grant and response (0..7).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered requests (1..8).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port instr_req_in  input  1  fetch request.
REQ-007 SHALL have port instr_addr_in  input  32  byte address of the requested instruction.
REQ-008 SHALL have port gnt_out  output  1  request accepted this cycle.
REQ-009 SHALL have port instr_rvalid_out  output  1  response valid this cycle.
REQ-010 SHALL have port instr_rdata_out  output  32  instruction word.
REQ-011 SHALL have port instr_err_out  output  1  response is an error; valid with rvalid.
REQ-012 SHALL have port load_en_in  input  1  program-load write enable.
REQ-013 SHALL have port load_addr_in  input  32  program-load byte address.
REQ-014 SHALL have port load_data_in  input  32  program-load word.

Function
REQ-015 gnt_out SHALL equal instr_req_in AND NOT load_en_in AND (outstanding < MAX_OUTSTANDING) AND NOT rst, combinationally.
REQ-016 A request granted at edge N SHALL produce exactly one response with rvalid high in the cycle after edge N+1+WAIT_STATES.
REQ-017 Responses SHALL be returned in grant order; back-to-back grants on consecutive cycles SHALL yield rvalid on consecutive cycles.
REQ-018 rdata SHALL be mem[addr[log2(MEM_DEPTH)+1:2]] sampled at grant time.
REQ-019 Address with addr[1:0] != 0, or word index >= MEM_DEPTH, SHALL give err=1, rdata=0.
REQ-020 err and rdata SHALL be 0 whenever rvalid is 0.
REQ-021 The outstanding counter SHALL increment on grant, decrement on rvalid, stay unchanged when both occur in the same cycle, and never exceed MAX_OUTSTANDING or go below 0.
REQ-022 A load with load_en_in=1 SHALL write load_data_in to the indexed word at the edge; out-of-range or misaligned loads SHALL be ignored.
REQ-023 A read granted in the cycle after a load to the same word SHALL return the new data.
REQ-024 The responder SHALL ignore branch/flush events; every granted request SHALL be answered (the requester drops stale data).
REQ-025 There SHALL be no rvalid backpressure; the requester accepts every response.

Reset
REQ-026 In reset: gnt_out=0, instr_rvalid_out=0, instr_rdata_out=0, instr_err_out=0, outstanding=0, response pipeline cleared.
REQ-027 Reset asserted with requests in flight SHALL discard them; no rvalid SHALL appear for them after reset release.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 First grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-030 Protocol constants (data width 32, max WAIT_STATES, error code values) SHALL live in shared package soc_pkg.
REQ-031 The in-order fixed-latency response delay line (valid, data, err per stage) SHALL be sub-module resp_pipe, parameterised by depth WAIT_STATES+1.
REQ-032 The memory array SHALL be a single synchronous-write, grant-time-read array inside instr_mem_responder.

Verification
REQ-033 Load 0x00000013 at 0x0, WAIT_STATES=1, req addr 0x0 at cycle 0 -> gnt cycle 0, rvalid=1 with rdata 0x00000013, err=0 at cycle 2.
REQ-034 Req held high with MAX_OUTSTANDING=2, WAIT_STATES=3, addrs 0x0, 0x4, 0x8 -> gnt on first two cycles, gnt=0 until first rvalid, then third grant; responses in order.
REQ-035 Req addr 0x2 and 0x1000 (MEM_DEPTH=1024) -> rvalid with err=1, rdata=0 for each.
REQ-036 load_en_in=1 with req high -> gnt=0 that cycle; next-cycle req to the loaded word returns the new data.
REQ-037 Two grants in flight, rst pulsed one cycle -> no rvalid thereafter, outstanding=0, next req granted immediately.
REQ-038 WAIT_STATES=0, req every cycle to 0x0,0x4,0x8,0xC -> rvalid on four consecutive cycles starting one cycle after the first grant, data in address order.
